// File: rtl/past_sum_averager.sv
// Window-sum to window-average scaler with warm-up discard, output FIFO, peak and drop tracking.
// Optional feature: define AVG_ROUND_EN for round-half-up averaging (default truncates).
module past_sum_averager #(
    parameter int DW         = 8,
    parameter int N          = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DW-1:0]                 sum_in,
    input  logic                          sum_valid,
    output logic [DW-1:0]                 avg_out,
    output logic                          avg_valid,
    input  logic                          avg_ready,
    output logic [DW-1:0]                 peak_out,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int LOG2N = $clog2(N);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;
    localparam logic [LOG2N-1:0] WARM_LAST = LOG2N'(N - 2);
    localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic {WARMUP, RUN} state_t;

    state_t            state_q, state_d;
    logic [LOG2N-1:0]  warm_q, warm_d;
    logic [DW-1:0]     res_q, res_d;
    logic              res_valid_q, res_valid_d;
    logic [DW-1:0]     mem_q [FIFO_DEPTH];
    logic [DW-1:0]     mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DW-1:0]     peak_q, peak_d;
    logic              overflow_q, overflow_d;

    logic [DW:0]       avg_wide;
    logic              full, pop, push_ok, drop;

    // Intermediate is one bit wider so the rounding offset cannot wrap.
    always_comb begin
`ifdef AVG_ROUND_EN
        avg_wide = ({1'b0, sum_in} + (DW+1)'(N / 2)) >> LOG2N;
`else
        avg_wide = {1'b0, sum_in} >> LOG2N;
`endif
    end

    always_comb begin
        state_d     = state_q;
        warm_d      = warm_q;
        res_d       = res_q;
        res_valid_d = 1'b0;
        if (sum_valid) begin
            if (state_q == WARMUP) begin
                if (warm_q == WARM_LAST) begin
                    state_d = RUN;
                end else begin
                    warm_d = warm_q + LOG2N'(1);
                end
            end else begin
                res_valid_d = 1'b1;
                res_d       = avg_wide[DW-1:0];
            end
        end
    end

    assign full    = (count_q == FULL_CNT);
    assign pop     = avg_valid && avg_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok = res_valid_q && (!full || pop);
    assign drop    = res_valid_q && full && !pop;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + CW'(push_ok) - CW'(pop);
        peak_d     = peak_q;
        overflow_d = overflow_q | drop;
        if (push_ok) begin
            mem_d[wr_ptr_q] = res_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
            if (res_q > peak_q) begin
                peak_d = res_q;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WARMUP;
            warm_q      <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            peak_q      <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_q      <= warm_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            peak_q      <= peak_d;
            overflow_q  <= overflow_d;
        end
    end

    assign avg_out    = mem_q[rd_ptr_q];
    assign avg_valid  = (count_q != '0);
    assign peak_out   = peak_q;
    assign overflow   = overflow_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_past_sum_averager.sv
// Directed bench for past_sum_averager (DW=8, N=4, FIFO_DEPTH=4); follows AVG_ROUND_EN if defined.
module tb_past_sum_averager;

    logic       clk;
    logic       rst_n;
    logic [7:0] sum_in;
    logic       sum_valid;
    logic [7:0] avg_out;
    logic       avg_valid;
    logic       avg_ready;
    logic [7:0] peak_out;
    logic       overflow;
    logic [2:0] fifo_count;

    int tests_run = 0;
    int fails     = 0;

    past_sum_averager #(.DW(8), .N(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sum_in     (sum_in),
        .sum_valid  (sum_valid),
        .avg_out    (avg_out),
        .avg_valid  (avg_valid),
        .avg_ready  (avg_ready),
        .peak_out   (peak_out),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        sum_in    = '0;
        sum_valid = 1'b0;
        avg_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Drive one valid sum for a single cycle.
    task automatic push_sum(input logic [7:0] s);
        sum_valid = 1'b1;
        sum_in    = s;
        tick();
        sum_valid = 1'b0;
    endtask

    task automatic warm_up();
        push_sum(8'd0);
        push_sum(8'd0);
        push_sum(8'd0);
    endtask

    task automatic check(input string name, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        sum_in    = '0;
        sum_valid = 1'b0;
        avg_ready = 1'b0;
        #3;
        tests_run++;
        if (avg_valid !== 1'b0) begin fails++; $display("FAIL reset_avg_valid: got %0d expected 0", avg_valid); end
        tests_run++;
        if (avg_out !== 8'd0) begin fails++; $display("FAIL reset_avg_out: got %0d expected 0", avg_out); end
        tests_run++;
        if (peak_out !== 8'd0) begin fails++; $display("FAIL reset_peak: got %0d expected 0", peak_out); end
        tests_run++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %0d expected 0", overflow); end
        tests_run++;
        if (fifo_count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        do_reset();
    endtask

    task automatic test_warmup();
        do_reset();
        push_sum(8'd10);
        push_sum(8'd20);
        push_sum(8'd30);
        tick();
        tick();
        tests_run++;
        if (fifo_count !== 3'd0) begin fails++; $display("FAIL warmup_discard: got %0d expected 0", fifo_count); end
        push_sum(8'd40);
        tests_run++;
        if (avg_valid !== 1'b0) begin fails++; $display("FAIL warmup_latency1: got %0d expected 0", avg_valid); end
        tick();
        tests_run++;
        if (avg_valid !== 1'b1) begin fails++; $display("FAIL warmup_valid: got %0d expected 1", avg_valid); end
        tests_run++;
        if (avg_out !== 8'd10) begin fails++; $display("FAIL warmup_avg: got %0d expected 10", avg_out); end
        tests_run++;
        if (fifo_count !== 3'd1) begin fails++; $display("FAIL warmup_count: got %0d expected 1", fifo_count); end
    endtask

    task automatic test_rounding();
        logic [7:0] e6, e255;
`ifdef AVG_ROUND_EN
        e6 = 8'd2;  e255 = 8'd64;
`else
        e6 = 8'd1;  e255 = 8'd63;
`endif
        do_reset();
        warm_up();
        push_sum(8'd6);
        push_sum(8'd255);
        tick();
        tests_run++;
        if (fifo_count !== 3'd2) begin fails++; $display("FAIL round_count: got %0d expected 2", fifo_count); end
        tests_run++;
        if (avg_out !== e6) begin fails++; $display("FAIL round_sum6: got %0d expected %0d", avg_out, e6); end
        avg_ready = 1'b1;
        tick();
        avg_ready = 1'b0;
        tests_run++;
        if (avg_out !== e255) begin fails++; $display("FAIL round_sum255: got %0d expected %0d", avg_out, e255); end
        tests_run++;
        if (fifo_count !== 3'd1) begin fails++; $display("FAIL round_pop_count: got %0d expected 1", fifo_count); end
    endtask

    task automatic test_backpressure();
        do_reset();
        warm_up();
        for (int i = 1; i <= 6; i++) push_sum(8'(4 * i));
        tick();
        tick();
        tests_run++;
        if (fifo_count !== 3'd4) begin fails++; $display("FAIL bp_count: got %0d expected 4", fifo_count); end
        tests_run++;
        if (overflow !== 1'b1) begin fails++; $display("FAIL bp_overflow: got %0d expected 1", overflow); end
        tests_run++;
        if (peak_out !== 8'd4) begin fails++; $display("FAIL bp_peak_no_drop: got %0d expected 4", peak_out); end
        tick();
        tests_run++;
        if (avg_out !== 8'd1) begin fails++; $display("FAIL bp_held: got %0d expected 1", avg_out); end
        avg_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tests_run++;
            if (avg_valid !== 1'b1 || avg_out !== 8'(i)) begin
                fails++;
                $display("FAIL bp_drain%0d: got %0d (valid %0d) expected %0d", i, avg_out, avg_valid, i);
            end
            tick();
        end
        avg_ready = 1'b0;
        tests_run++;
        if (avg_valid !== 1'b0) begin fails++; $display("FAIL bp_empty: got %0d expected 0", avg_valid); end
    endtask

    task automatic test_full_pop_push();
        logic [7:0] exp_q[$];
        do_reset();
        warm_up();
        for (int i = 1; i <= 4; i++) push_sum(8'(4 * i));
        tick();
        tests_run++;
        if (fifo_count !== 3'd4) begin fails++; $display("FAIL fpp_prefill: got %0d expected 4", fifo_count); end
        // Result registers on this edge; pop lines up with the push on the next.
        push_sum(8'd40);
        avg_ready = 1'b1;
        tick();
        avg_ready = 1'b0;
        tests_run++;
        if (fifo_count !== 3'd4) begin fails++; $display("FAIL fpp_count: got %0d expected 4", fifo_count); end
        tests_run++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL fpp_overflow: got %0d expected 0", overflow); end
        exp_q = '{8'd2, 8'd3, 8'd4, 8'd10};
        avg_ready = 1'b1;
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            tests_run++;
            if (avg_out !== e) begin fails++; $display("FAIL fpp_order: got %0d expected %0d", avg_out, e); end
            tick();
        end
        avg_ready = 1'b0;
    endtask

    task automatic test_peak();
        do_reset();
        warm_up();
        avg_ready = 1'b1;
        push_sum(8'd20);
        tick();
        tests_run++;
        if (peak_out !== 8'd5) begin fails++; $display("FAIL peak_5: got %0d expected 5", peak_out); end
        push_sum(8'd36);
        tick();
        tests_run++;
        if (peak_out !== 8'd9) begin fails++; $display("FAIL peak_9: got %0d expected 9", peak_out); end
        push_sum(8'd12);
        tick();
        tests_run++;
        if (peak_out !== 8'd9) begin fails++; $display("FAIL peak_hold: got %0d expected 9", peak_out); end
        tick();
        avg_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_sum(8'd4);
        push_sum(8'd252);
        tick();
        tick();
        tests_run++;
        if (overflow !== 1'b1) begin fails++; $display("FAIL peak_drop_ovf: got %0d expected 1", overflow); end
        tests_run++;
        if (peak_out !== 8'd9) begin fails++; $display("FAIL peak_drop: got %0d expected 9", peak_out); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        warm_up();
        for (int i = 1; i <= 5; i++) push_sum(8'(40 + 4 * i));
        tick();
        avg_ready = 1'b1;
        tick();
        avg_ready = 1'b0;
        tests_run++;
        if (fifo_count !== 3'd3 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL mid_setup: got count %0d ovf %0d expected 3 1", fifo_count, overflow);
        end
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (avg_valid !== 1'b0) begin fails++; $display("FAIL mid_valid: got %0d expected 0", avg_valid); end
        tests_run++;
        if (peak_out !== 8'd0) begin fails++; $display("FAIL mid_peak: got %0d expected 0", peak_out); end
        tests_run++;
        if (overflow !== 1'b0) begin fails++; $display("FAIL mid_overflow: got %0d expected 0", overflow); end
        tests_run++;
        if (fifo_count !== 3'd0) begin fails++; $display("FAIL mid_count: got %0d expected 0", fifo_count); end
        tick();
        rst_n = 1'b1;
        push_sum(8'd100);
        push_sum(8'd100);
        push_sum(8'd100);
        tick();
        tick();
        tests_run++;
        if (fifo_count !== 3'd0) begin fails++; $display("FAIL mid_rewarm: got %0d expected 0", fifo_count); end
        push_sum(8'd100);
        tick();
        tests_run++;
        if (fifo_count !== 3'd1 || avg_out !== 8'd25) begin
            fails++;
            $display("FAIL mid_first: got count %0d avg %0d expected 1 25", fifo_count, avg_out);
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_rounding();
        test_backpressure();
        test_full_pop_push();
        test_peak();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
